// File: rtl/fetch_top.sv
// fetch_top: FETCH pipeline stage.
// Owns the PC, issues instruction-memory requests over a level req/valid
// handshake and drives the IF/ID boundary registers consumed by DECODE.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   pc_write            - DECODE: 0 holds the PC (hazard stall)
//   if_id_write         - DECODE: 0 holds the IF/ID boundary
//   branch_taken        - M stage redirect request (highest priority)
//   branch_target       - redirect PC, taken verbatim
//   imem_req/imem_addr  - request to instruction memory
//   imem_valid/rdata    - memory response (same cycle on hit, later on miss)
//   out_pc/out_instr    - IF/ID registers: PC and instruction to DECODE
//   out_valid           - IF/ID register: 0 marks a bubble
module fetch_top #(
    parameter int unsigned           ADDR_SIZE  = 32,
    parameter int unsigned           INSTR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0]  RESET_PC   = ADDR_SIZE'(32'h0000_1000),
    parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = INSTR_SIZE'(32'h0000_0000)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_write,
    input  logic                  if_id_write,
    input  logic                  branch_taken,
    input  logic [ADDR_SIZE-1:0]  branch_target,
    output logic                  imem_req,
    output logic [ADDR_SIZE-1:0]  imem_addr,
    input  logic                  imem_valid,
    input  logic [INSTR_SIZE-1:0] imem_rdata,
    output logic [ADDR_SIZE-1:0]  out_pc,
    output logic [INSTR_SIZE-1:0] out_instr,
    output logic                  out_valid
);

    localparam logic [ADDR_SIZE-1:0] PC_STEP = ADDR_SIZE'(4);

    // REQ: request outstanding at pc; HOLD: response parked while stalled;
    // DRAIN: waiting out a response made stale by a redirect.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                  state_q,      state_d;
    logic [ADDR_SIZE-1:0]    pc_q,         pc_d;
    logic [ADDR_SIZE-1:0]    drain_addr_q, drain_addr_d;
    logic [INSTR_SIZE-1:0]   buf_q,        buf_d;
    logic [ADDR_SIZE-1:0]    out_pc_q,     out_pc_d;
    logic [INSTR_SIZE-1:0]   out_instr_q,  out_instr_d;
    logic                    out_valid_q,  out_valid_d;
    logic                    adv;

    // Memory side: the request stays up (address stable) until valid is seen.
    // In DRAIN the old address is kept because a request cannot be cancelled.
    assign imem_req  = !reset && (state_q != ST_HOLD);
    assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_valid = out_valid_q;

    // Next-state and IF/ID update logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_d        = buf_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        out_valid_d  = out_valid_q;
        adv          = pc_write & if_id_write;

        if (branch_taken) begin
            // Redirect overrides stalls and always flushes IF/ID to a bubble.
            pc_d        = branch_target;
            out_pc_d    = '0;
            out_instr_d = NOP_INSTR;
            out_valid_d = 1'b0;
            buf_d       = NOP_INSTR;
            unique case (state_q)
                ST_REQ: begin
                    // Same-cycle response is simply dropped; otherwise the
                    // outstanding request must be drained at its old address.
                    if (!imem_valid) begin
                        state_d      = ST_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                ST_HOLD:  state_d = ST_REQ;
                ST_DRAIN: begin
                    if (imem_valid) begin
                        state_d = ST_REQ;
                    end
                end
                default:  state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (imem_valid) begin
                        if (adv) begin
                            out_pc_d    = pc_q;
                            out_instr_d = imem_rdata;
                            out_valid_d = 1'b1;
                            pc_d        = pc_q + PC_STEP;
                        end else begin
                            buf_d   = imem_rdata;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (adv) begin
                        out_pc_d    = pc_q;
                        out_instr_d = buf_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + PC_STEP;
                        state_d     = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // Stale response discarded; pc already holds the target.
                    if (imem_valid) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // State and IF/ID registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            buf_q        <= NOP_INSTR;
            out_pc_q     <= '0;
            out_instr_q  <= NOP_INSTR;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_q        <= buf_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule

// File: doc/fetch_top.md
Name: fetch_top

Overview:
- FETCH stage: sits directly upstream of the DECODE stage.
- Owns the PC register and issues instruction-memory requests through a level req/valid handshake.
- Drives the IF/ID boundary registers (pc, instruction, valid) that DECODE consumes.
- Honours DECODE's hazard stall (pc_write / if_id_write) and the M-stage branch redirect, which flushes the IF/ID boundary to a NOP bubble.

Parameters:
- ADDR_SIZE, 32, PC / memory address width.
- INSTR_SIZE, 32, instruction width.
- RESET_PC, 32'h0000_1000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction; decodes as no writes, no memory access, no branch.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pc_write  in  1  from DECODE; 0 = hold PC (hazard stall).
- if_id_write  in  1  from DECODE; 0 = hold IF/ID boundary.
- branch_taken  in  1  from M stage; redirect request.
- branch_target  in  ADDR_SIZE  redirect PC.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  ADDR_SIZE  request address.
- imem_valid  in  1  response valid; may rise the same cycle as imem_req (hit) or later (miss).
- imem_rdata  in  INSTR_SIZE  response instruction.
- out_pc  out  ADDR_SIZE  IF/ID register: PC of out_instr.
- out_instr  out  INSTR_SIZE  IF/ID register: instruction to DECODE.
- out_valid  out  1  IF/ID register: 0 = bubble.

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC; state = REQ.
  - out_pc = 0; out_instr = NOP_INSTR; out_valid = 0.
  - Holding buffer cleared.
  - Any in-flight memory response is forgotten; imem_req drops to 0 while reset is high.
- Define adv = pc_write & if_id_write.
- State REQ:
  - imem_req = 1; imem_addr = pc.
  - imem_addr is held stable until imem_valid is seen.
  - On imem_valid & adv: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4; stay REQ. Throughput is 1 instruction/cycle on hits.
  - On imem_valid & !adv: holding buffer <= imem_rdata; go HOLD; IF/ID unchanged.
  - No imem_valid: stay REQ; IF/ID unchanged.
- State HOLD:
  - imem_req = 0.
  - On adv: IF/ID <= {pc, buffer, 1}; pc <= pc+4; go REQ.
- State DRAIN:
  - imem_req = 1 with the old address; a request cannot be cancelled.
  - On imem_valid: data is discarded; go REQ (pc already holds the target).
- Redirect (branch_taken = 1) has the highest priority and overrides stalls:
  - pc <= branch_target.
  - IF/ID <= {0, NOP_INSTR, 0} regardless of if_id_write.
  - Holding buffer invalidated.
  - Next state:
    - REQ without imem_valid (request outstanding): DRAIN.
    - REQ with imem_valid in the same cycle: response dropped; REQ.
    - HOLD: REQ.
    - DRAIN: stays DRAIN until the pending response arrives. The target is replaced by the newest branch_target.
- PC arithmetic: pc+4 is modulo 2^ADDR_SIZE; wrap from 32'hFFFF_FFFC to 0 is silent.
  - branch_target is taken verbatim, with no alignment check.
- Stall with no response (REQ, !imem_valid, !adv): nothing changes.
- Latency: with a memory hit, an instruction reaches out_instr one clock edge after imem_req is asserted with its address.
- imem_req is combinational from state. All IF/ID outputs are registers.

Test Plan:
1. Reset release, memory always hits with rdata = addr^0xA5A5A5A5, adv = 1 -> out_pc sequence 0x1000, 0x1004, 0x1008 on consecutive cycles, out_valid = 1.
2. Miss: imem_valid delayed 3 cycles at pc 0x1004 -> imem_addr held at 0x1004 for 4 cycles; out_instr/out_pc unchanged until valid; then 0x1004 delivered.
3. Stall: if_id_write = pc_write = 0 for 2 cycles while a hit returns at 0x1008 -> state HOLD, imem_req = 0, IF/ID frozen. On release, 0x1008 instruction is delivered once and the next request is 0x100C.
4. Branch to 0x2000 during a 2-cycle miss at 0x1010 -> next out_valid = 0, out_instr = NOP. Late 0x1010 data is never delivered; next request addr = 0x2000; then 0x2000 delivered.
5. branch_taken during stall (if_id_write = 0) in HOLD -> IF/ID flushed to bubble anyway; pc = target; state REQ.
6. Reset asserted mid-miss -> outputs return to reset values immediately (async); imem_req = 0. After release, the first request addr = 0x1000.
